// File: rtl/sm_controller_if.sv
// Handshake and datapath-control bundle between the instruction fetch side and sm_controller.
interface sm_controller_if;
  logic [15:0] instr_in;
  logic        load_ir;
  logic        s;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic [1:0]  vsel;
  logic        loada;
  logic        loadb;
  logic        asel;
  logic        bsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic        loadc;
  logic        loads;
  logic [15:0] sximm8;
  logic [15:0] sximm5;

  modport master (
    output instr_in, load_ir, s,
    input  w, readnum, writenum, write, vsel, loada, loadb, asel, bsel,
           shift, ALUop, loadc, loads, sximm8, sximm5
  );

  modport slave (
    input  instr_in, load_ir, s,
    output w, readnum, writenum, write, vsel, loada, loadb, asel, bsel,
           shift, ALUop, loadc, loads, sximm8, sximm5
  );
endinterface

// File: rtl/sm_controller.sv
// Instruction register plus Moore decode FSM that sequences one instruction
// over several clocks by driving the 16-bit datapath control inputs.
module sm_controller (
  input  logic           clk,
  input  logic           reset,
  sm_controller_if.slave bus
);
  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_EXEC, S_WR_IMM, S_WR_REG
  } state_t;

  state_t      r_state, w_next;
  logic [15:0] r_ir;

  logic [2:0] w_opcode, w_rn, w_rd, w_rm;
  logic [1:0] w_op, w_sh;
  logic       w_is_movi, w_is_movr, w_is_alu, w_is_mvn, w_is_cmp;

  assign w_opcode  = r_ir[15:13];
  assign w_op      = r_ir[12:11];
  assign w_rn      = r_ir[10:8];
  assign w_rd      = r_ir[7:5];
  assign w_sh      = r_ir[4:3];
  assign w_rm      = r_ir[2:0];
  assign w_is_movi = (w_opcode == 3'b110) && (w_op == 2'b10);
  assign w_is_movr = (w_opcode == 3'b110) && (w_op == 2'b00);
  assign w_is_alu  = (w_opcode == 3'b101);
  assign w_is_mvn  = w_is_alu && (w_op == 2'b11);
  assign w_is_cmp  = w_is_alu && (w_op == 2'b01);

  assign bus.sximm8 = {{8{r_ir[7]}}, r_ir[7:0]};
  assign bus.sximm5 = {{11{r_ir[4]}}, r_ir[4:0]};

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_WAIT;
    else       r_state <= w_next;
  end

  // IR only accepts a new word while idle, so DECODE sees the word loaded alongside s.
  always_ff @(posedge clk) begin
    if (reset)                               r_ir <= 16'h0000;
    else if (r_state == S_WAIT && bus.load_ir) r_ir <= bus.instr_in;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT:   if (bus.s) w_next = S_DECODE;
      S_DECODE: begin
        if (w_is_movi)                   w_next = S_WR_IMM;
        else if (w_is_movr || w_is_mvn)  w_next = S_GET_B;
        else if (w_is_alu)               w_next = S_GET_A;
        else                             w_next = S_WAIT;
      end
      S_GET_A:  w_next = S_GET_B;
      S_GET_B:  w_next = S_EXEC;
      S_EXEC:   w_next = w_is_cmp ? S_WAIT : S_WR_REG;
      S_WR_IMM: w_next = S_WAIT;
      S_WR_REG: w_next = S_WAIT;
      default:  w_next = S_WAIT;
    endcase
  end

  always_comb begin
    bus.w        = 1'b0;
    bus.readnum  = 3'd0;
    bus.writenum = 3'd0;
    bus.write    = 1'b0;
    bus.vsel     = 2'b00;
    bus.loada    = 1'b0;
    bus.loadb    = 1'b0;
    bus.asel     = 1'b0;
    bus.bsel     = 1'b0;
    bus.shift    = 2'b00;
    bus.ALUop    = 2'b00;
    bus.loadc    = 1'b0;
    bus.loads    = 1'b0;
    case (r_state)
      S_WAIT:  bus.w = 1'b1;
      S_GET_A: begin
        bus.readnum = w_rn;
        bus.loada   = 1'b1;
      end
      S_GET_B: begin
        bus.readnum = w_rm;
        bus.loadb   = 1'b1;
      end
      S_EXEC: begin
        bus.shift = w_sh;
        // MOV reg passes the shifted B through the adder with A forced to zero.
        if (w_is_mvn) begin
          bus.asel  = 1'b1;
          bus.ALUop = 2'b11;
        end else if (w_is_movr) begin
          bus.asel  = 1'b1;
          bus.ALUop = 2'b00;
        end else begin
          bus.ALUop = w_op;
        end
        bus.loads = w_is_cmp;
        bus.loadc = ~w_is_cmp;
      end
      S_WR_IMM: begin
        bus.writenum = w_rn;
        bus.vsel     = 2'b10;
        bus.write    = 1'b1;
      end
      S_WR_REG: begin
        bus.writenum = w_rd;
        bus.write    = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_sm_controller.sv
// Scoreboard bench for sm_controller: expected strobe cycles and completion
// latencies are queued by the stimulus and matched by a negedge monitor.
module tb_sm_controller;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sm_controller_if bus ();
  sm_controller dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [2:0] rn;
    logic [2:0] wn;
    logic       wr;
    logic [1:0] vs;
    logic       la, lb, as, bs;
    logic [1:0] sh, op;
    logic       lc, ls;
    logic       dn;
    logic [7:0] lat;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk = 0;
  int  n_fail = 0;
  int  edges = 0;
  bit  busy = 0;

  function automatic ev_t stb(input logic [2:0] rn, wn, input logic wr, input logic [1:0] vs,
                              input logic la, lb, as, bs, input logic [1:0] sh, op,
                              input logic lc, ls);
    ev_t e;
    e = '{rn:rn, wn:wn, wr:wr, vs:vs, la:la, lb:lb, as:as, bs:bs, sh:sh, op:op,
          lc:lc, ls:ls, dn:1'b0, lat:8'd0};
    return e;
  endfunction
  function automatic ev_t e_a(input logic [2:0] rn);
    return stb(rn, 3'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
  endfunction
  function automatic ev_t e_b(input logic [2:0] rm);
    return stb(rm, 3'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
  endfunction
  function automatic ev_t e_x(input logic as, input logic [1:0] sh, op, input logic lc, ls);
    return stb(3'd0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, as, 1'b0, sh, op, lc, ls);
  endfunction
  function automatic ev_t e_w(input logic [2:0] wn, input logic [1:0] vs);
    return stb(3'd0, wn, 1'b1, vs, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
  endfunction
  function automatic ev_t e_d(input int lat);
    ev_t e;
    e = '0;
    e.dn  = 1'b1;
    e.lat = 8'(lat);
    return e;
  endfunction

  // Behavioural datapath driven by the controller's strobes.
  logic [15:0] R [8];
  logic [15:0] A, B, C, w_shout, w_ain, w_bin, w_alu;
  logic        Z;
  always_comb begin
    case (bus.shift)
      2'b00:   w_shout = B;
      2'b01:   w_shout = B << 1;
      2'b10:   w_shout = B >> 1;
      default: w_shout = {B[15], B[15:1]};
    endcase
    w_ain = bus.asel ? 16'h0000 : A;
    w_bin = bus.bsel ? bus.sximm5 : w_shout;
    case (bus.ALUop)
      2'b00:   w_alu = w_ain + w_bin;
      2'b01:   w_alu = w_ain - w_bin;
      2'b10:   w_alu = w_ain & w_bin;
      default: w_alu = ~w_bin;
    endcase
  end
  always @(posedge clk) begin
    if (reset && !busy && edges == 0) begin
      for (int i = 0; i < 8; i++) R[i] <= 16'h0000;
      A <= 16'h0; B <= 16'h0; C <= 16'h0; Z <= 1'b0;
    end else begin
      if (bus.write) R[bus.writenum] <= (bus.vsel == 2'b10) ? bus.sximm8 : C;
      if (bus.loada) A <= R[bus.readnum];
      if (bus.loadb) B <= R[bus.readnum];
      if (bus.loadc) C <= w_alu;
      if (bus.loads) Z <= (w_alu == 16'h0);
    end
  end

  // Monitor: every strobe cycle and every return to WAIT is matched against the queue.
  always @(negedge clk) begin
    ev_t obs, e;
    if (busy) edges++;
    if (bus.write | bus.loada | bus.loadb | bus.loadc | bus.loads) begin
      obs = stb(bus.readnum, bus.writenum, bus.write, bus.vsel, bus.loada, bus.loadb,
                bus.asel, bus.bsel, bus.shift, bus.ALUop, bus.loadc, bus.loads);
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL strobe_unexpected: got %h, required none", obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          n_fail++;
          $display("FAIL strobe: got %h, required %h", obs, e);
        end
      end
    end
    if (busy && bus.w) begin
      obs = e_d(edges);
      busy = 0;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL done_unexpected: got lat %0d, required none", edges);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          n_fail++;
          $display("FAIL done: got %h (lat %0d), required %h", obs, edges, e);
        end
      end
    end
    if (bus.w && bus.s && !reset) begin
      busy  = 1;
      edges = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic load(input logic [15:0] ins);
    @(posedge clk); #1;
    bus.load_ir  = 1'b1;
    bus.instr_in = ins;
    @(posedge clk); #1;
    bus.load_ir  = 1'b0;
  endtask

  task automatic go();
    bus.s = 1'b1;
    @(posedge clk); #1;
    bus.s = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (busy && k < 30) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (busy) begin
      n_fail++;
      $display("FAIL timeout: busy after %0d cycles, required idle", k);
      busy = 0;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset        = 1'b1;
    bus.s        = 1'b0;
    bus.load_ir  = 1'b0;
    bus.instr_in = 16'h0000;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_w", 32'(bus.w), 32'd1);
    chk("rst_strobes", {bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads, bus.asel, bus.bsel}, 32'd0);
    chk("rst_idx", {bus.readnum, bus.writenum, bus.vsel, bus.shift, bus.ALUop}, 32'd0);
    chk("rst_sximm8", 32'(bus.sximm8), 32'd0);
    chk("rst_sximm5", 32'(bus.sximm5), 32'd0);

    // MOV R3,#-2
    exp_q.push_back(e_w(3'd3, 2'b10));
    exp_q.push_back(e_d(3));
    load(16'hD3FE);
    chk("movi_sximm8", 32'(bus.sximm8), 32'h0000FFFE);
    chk("movi_sximm5", 32'(bus.sximm5), 32'h0000FFFE);
    go();
    wait_done();
    chk("movi_R3", 32'(R[3]), 32'h0000FFFE);

    // Preload R5 = 0x23, R3 = 0x42
    exp_q.push_back(e_w(3'd5, 2'b10));
    exp_q.push_back(e_d(3));
    load(16'hD523);
    go();
    wait_done();
    exp_q.push_back(e_w(3'd3, 2'b10));
    exp_q.push_back(e_d(3));
    load(16'hD342);
    go();
    wait_done();

    // ADD R2,R5,R3
    exp_q.push_back(e_a(3'd5));
    exp_q.push_back(e_b(3'd3));
    exp_q.push_back(e_x(1'b0, 2'b00, 2'b00, 1'b1, 1'b0));
    exp_q.push_back(e_w(3'd2, 2'b00));
    exp_q.push_back(e_d(6));
    load(16'hA543);
    go();
    wait_done();
    chk("add_R2", 32'(R[2]), 32'h00000065);

    // CMP R6,R4
    exp_q.push_back(e_a(3'd6));
    exp_q.push_back(e_b(3'd4));
    exp_q.push_back(e_x(1'b0, 2'b00, 2'b01, 1'b0, 1'b1));
    exp_q.push_back(e_d(5));
    load(16'hAE04);
    go();
    wait_done();

    // MVN R3,R1,LSL#1 with R1 = 0
    exp_q.push_back(e_b(3'd1));
    exp_q.push_back(e_x(1'b1, 2'b01, 2'b11, 1'b1, 1'b0));
    exp_q.push_back(e_w(3'd3, 2'b00));
    exp_q.push_back(e_d(5));
    load(16'hB869);
    go();
    wait_done();
    chk("mvn_R3", 32'(R[3]), 32'h0000FFFF);

    // load_ir during GET_A must be ignored
    exp_q.push_back(e_a(3'd5));
    exp_q.push_back(e_b(3'd3));
    exp_q.push_back(e_x(1'b0, 2'b00, 2'b00, 1'b1, 1'b0));
    exp_q.push_back(e_w(3'd2, 2'b00));
    exp_q.push_back(e_d(6));
    load(16'hA543);
    go();
    @(posedge clk); #1;
    bus.load_ir  = 1'b1;
    bus.instr_in = 16'hD0FF;
    @(posedge clk); #1;
    bus.load_ir  = 1'b0;
    wait_done();
    chk("ir_hold_sximm8", 32'(bus.sximm8), 32'h00000043);

    // Reset during EXEC aborts the ADD before its write
    exp_q.push_back(e_a(3'd5));
    exp_q.push_back(e_b(3'd3));
    exp_q.push_back(e_x(1'b0, 2'b00, 2'b00, 1'b1, 1'b0));
    exp_q.push_back(e_d(5));
    go();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    wait_done();
    chk("abort_w", 32'(bus.w), 32'd1);
    chk("abort_ir_cleared", 32'(bus.sximm8), 32'd0);

    // Undefined opcode: NOP in two edges
    exp_q.push_back(e_d(2));
    load(16'h0000);
    go();
    wait_done();

    repeat (4) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
